// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide adder sequencer: the limb width and the
// controller state encoding.
package wide_add_sequencer_pkg;

   localparam int LIMB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      CARRY = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Requester-side bundle: start/operands in, busy/done/result out.
// The master modport is the requester and the slave modport is the sequencer.
interface wide_add_sequencer_if #(parameter int NBYTES = 4);
   import wide_add_sequencer_pkg::*;

   localparam int W = LIMB * NBYTES;

   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output start, op_a, op_b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/wide_add_sequencer_bit8adder.sv
// The existing shared 8-bit adder: f = a + b with the carry in f[8]; it has
// no carry input, so the sequencer folds carries in with a second pass.
module bit8adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [8:0] f
);

   assign f = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/wide_add_sequencer.sv
// NBYTES-wide add with carry-in, computed one limb at a time on a single
// 8-bit adder: per limb, one pass adds the operand bytes, a second adds the carry.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   wide_add_sequencer_if.slave bus
);

   localparam int W    = LIMB * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [LIMB-1:0]   partial_q, partial_d;
   logic              c1_q, c1_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [LIMB-1:0]   add_a;
   logic [LIMB-1:0]   add_b;
   logic [LIMB:0]     add_f;

   // The shared adder sees operand bytes in ADD and partial + carry in CARRY.
   always_comb begin
      add_a = '0;
      add_b = '0;
      case (state_q)
         ADD: begin
            for (int i = 0; i < NBYTES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  add_a = a_q[i*LIMB +: LIMB];
                  add_b = b_q[i*LIMB +: LIMB];
               end
            end
         end
         CARRY: begin
            add_a = partial_q;
            add_b = {{(LIMB-1){1'b0}}, carry_q};
         end
         default: ;
      endcase
   end

   bit8adder u_adder (
      .a (add_a),
      .b (add_b),
      .f (add_f)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      partial_d = partial_q;
      c1_d      = c1_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            partial_d = add_f[LIMB-1:0];
            c1_d      = add_f[LIMB];
            state_d   = CARRY;
         end
         CARRY: begin
            // c1 and the second-pass carry are mutually exclusive, so OR is exact.
            for (int i = 0; i < NBYTES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  sum_d[i*LIMB +: LIMB] = add_f[LIMB-1:0];
               end
            end
            carry_d = c1_q | add_f[LIMB];
            if (idx_q == IDXW'(NBYTES-1)) begin
               cout_d  = c1_q | add_f[LIMB];
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ADD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         partial_q <= '0;
         c1_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         partial_q <= partial_d;
         c1_q      <= c1_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at NBYTES=4 and NBYTES=1.
module tb_wide_add_sequencer;

   logic clk;
   logic rst_n;

   int compared;
   int mismatched;

   wide_add_sequencer_if #(.NBYTES(4)) bus4 ();
   wide_add_sequencer_if #(.NBYTES(1)) bus1 ();

   wide_add_sequencer #(.NBYTES(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   wide_add_sequencer #(.NBYTES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic [31:0] expSum;
      logic        expCout;
   } vec_t;

   vec_t vecs [6];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Start one 32-bit operation, scramble the operand inputs after capture,
   // then wait (bounded) for done. lat is the cycle number of done, counting
   // the cycle right after the accepting edge as 1; 0 means it never came.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c,
                                output logic [31:0] s, output logic co,
                                output int lat, output int busyCnt);
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.op_a  = a;
      bus4.op_b  = b;
      bus4.cin   = c;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.op_a  = ~a;
      bus4.op_b  = ~b;
      bus4.cin   = ~c;
      lat     = 0;
      busyCnt = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         if (bus4.busy) busyCnt++;
         if (bus4.done) begin
            lat = n;
            break;
         end
      end
      s  = bus4.sum;
      co = bus4.cout;
   endtask

   task automatic runOne(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [7:0] s, output logic co, output int lat);
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.op_a  = a;
      bus1.op_b  = b;
      bus1.cin   = c;
      @(negedge clk);
      bus1.start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         if (bus1.done) begin
            lat = n;
            break;
         end
      end
      s  = bus1.sum;
      co = bus1.cout;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] s;
      logic        co;
      logic [7:0]  s1;
      logic        co1;
      logic [32:0] model;
      logic [8:0]  model1;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      int          lat;
      int          busyCnt;
      int          doneCnt;
      int          doneAt;
      int          activity;

      compared   = 0;
      mismatched = 0;

      vecs[0] = '{32'h0000000B, 32'h00000014, 1'b0, 32'h0000001F, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
      vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
      vecs[4] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0};
      vecs[5] = '{32'h7F7F7F7F, 32'h01010101, 1'b0, 32'h80808080, 1'b0};

      rst_n      = 1'b0;
      bus4.start = 1'b0;
      bus4.op_a  = '0;
      bus4.op_b  = '0;
      bus4.cin   = 1'b0;
      bus1.start = 1'b0;
      bus1.op_a  = '0;
      bus1.op_b  = '0;
      bus1.cin   = 1'b0;

      #1;
      checkOutput("reset_busy", 64'(bus4.busy), 64'd0);
      checkOutput("reset_done", 64'(bus4.done), 64'd0);
      checkOutput("reset_sum",  64'(bus4.sum),  64'd0);
      checkOutput("reset_cout", 64'(bus4.cout), 64'd0);
      checkOutput("reset_sum1", 64'(bus1.sum),  64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, s, co, lat, busyCnt);
         checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
         checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(busyCnt), 64'd9);
         checkOutput($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].expSum));
         checkOutput($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].expCout));
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_pulse", i), 64'(bus4.done), 64'd0);
         checkOutput($sformatf("vec%0d_idle_busy", i), 64'(bus4.busy), 64'd0);
         checkOutput($sformatf("vec%0d_sum_held", i), 64'(bus4.sum), 64'(vecs[i].expSum));
      end

      // start held high through the whole operation with changing operands
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.op_a  = 32'h12345678;
      bus4.op_b  = 32'h11111111;
      bus4.cin   = 1'b0;
      @(negedge clk);
      bus4.op_a  = 32'h01020304;
      bus4.op_b  = 32'h10203040;
      doneCnt = 0;
      doneAt  = 0;
      for (int n = 1; n <= 9; n++) begin
         if (n > 1) @(negedge clk);
         if (bus4.done) begin
            doneCnt++;
            doneAt = n;
         end
      end
      checkOutput("hold_done_count", 64'(doneCnt), 64'd1);
      checkOutput("hold_done_cycle", 64'(doneAt), 64'd9);
      checkOutput("hold_sum", 64'(bus4.sum), 64'h23456789);
      @(negedge clk);
      checkOutput("hold_idle_gap", 64'(bus4.busy), 64'd0);
      @(negedge clk);
      checkOutput("hold_reaccept", 64'(bus4.busy), 64'd1);
      bus4.start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         if (bus4.done) begin
            lat = n;
            break;
         end
      end
      checkOutput("hold_second_latency", 64'(lat), 64'd9);
      checkOutput("hold_second_sum", 64'(bus4.sum), 64'h11223344);

      // asynchronous reset during the CARRY pass of byte 2
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.op_a  = 32'h44332211;
      bus4.op_b  = 32'h11111111;
      bus4.cin   = 1'b0;
      @(negedge clk);
      bus4.start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("partial_sum_bytes", 64'(bus4.sum), 64'h00003322);
      checkOutput("partial_busy", 64'(bus4.busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_busy", 64'(bus4.busy), 64'd0);
      checkOutput("async_done", 64'(bus4.done), 64'd0);
      checkOutput("async_sum",  64'(bus4.sum),  64'd0);
      checkOutput("async_cout", 64'(bus4.cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      activity = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (bus4.busy || bus4.done) activity++;
      end
      checkOutput("post_reset_idle", 64'(activity), 64'd0);
      applyStimulus(32'h80000000, 32'h80000000, 1'b0, s, co, lat, busyCnt);
      checkOutput("post_reset_latency", 64'(lat), 64'd9);
      checkOutput("post_reset_sum", 64'(s), 64'd0);
      checkOutput("post_reset_cout", 64'(co), 64'd1);

      // random regression against op_a + op_b + cin
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         if (i % 4 == 0) ra = 32'hFFFFFFFF;
         model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
         applyStimulus(ra, rb, rc, s, co, lat, busyCnt);
         checkOutput($sformatf("rand4_%0d_latency", i), 64'(lat), 64'd9);
         checkOutput($sformatf("rand4_%0d_result", i), 64'({co, s}), 64'(model));
      end
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         if (i % 4 == 0) ra[7:0] = 8'hFF;
         model1 = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + 9'(rc);
         runOne(ra[7:0], rb[7:0], rc, s1, co1, lat);
         checkOutput($sformatf("rand1_%0d_latency", i), 64'(lat), 64'd3);
         checkOutput($sformatf("rand1_%0d_result", i), 64'({co1, s1}), 64'(model1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
